acc_bank: RTL and testbench
===========================

Name: acc_bank

Overview:
- Parametrised successor to the CPU's single 8-bit load-only accumulator.
- Provides a bank of NUM_ACC accumulators of WIDTH bits.
- Supports load, add, subtract, clear, and a multi-cycle repeated-add (multiply-by-accumulation), with status flags and a valid/ready command handshake.
- Sits between the control unit and the datapath; the control unit issues one command at a time.

Parameters:
- WIDTH, 8, accumulator/data width in bits (>=2)
- NUM_ACC, 4, number of accumulators (>=1)
- CNT_W, 4, width of repeat count for RADD
- SAT, 0, 1 = unsigned saturating ADD/SUB/RADD; 0 = wrap-around
- SEL_W, $clog2(NUM_ACC) (min 1), selector width (derived)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- op_valid  in  1  command present
- op_ready  out  1  bank can accept a command this cycle
- op  in  3  opcode: NOP=0, LOAD=1, ADD=2, SUB=3, CLR=4, RADD=5; 6,7 reserved
- sel  in  SEL_W  target accumulator
- data_in  in  WIDTH  operand
- cnt_in  in  CNT_W  repeat count (RADD only)
- rd_sel  in  SEL_W  read-port select
- acc_out  out  WIDTH  combinational read of acc[rd_sel]; 0 if rd_sel>=NUM_ACC
- result_valid  out  1  one-cycle pulse: command completed
- err  out  1  valid with result_valid: bad sel or reserved op
- flag_z  out  1  result zero
- flag_c  out  1  carry (ADD/RADD) / borrow (SUB)
- flag_v  out  1  signed overflow
- flag_n  out  1  result MSB

Behaviour:
- Reset (rst=0, async, any state):
  - all acc = 0, flags = 0, result_valid = 0, err = 0.
  - FSM = IDLE, op_ready = 1, internal counter = 0.
  - Applies mid-RADD: run aborted, no completion pulse.
- Acceptance: command is taken on a rising edge with op_valid=1 and op_ready=1. op_ready=1 only in IDLE. op_valid while not ready is ignored; the requester holds.
- FSM states: IDLE, RUN, DONE.
- Single-cycle ops (LOAD/ADD/SUB/CLR/NOP), in IDLE:
  - acc[sel] written at the accepting edge.
  - Flags updated at the same edge.
  - result_valid=1 for the following cycle.
  - FSM stays IDLE, so back-to-back commands run at 1/cycle.
- LOAD: acc=data_in. Flags: Z/N from result, C=V=0.
- CLR: acc=0. Flags: Z=1, others 0.
- ADD: computed at WIDTH+1 bits. C=sum[WIDTH]. V=(a,b same sign, result sign differs).
- SUB: a-b. C=borrow (a<b unsigned). V=signed overflow.
- SAT=1 clamps: ADD with C=1 gives all-ones; SUB with C=1 gives 0. C/V report the unclamped operation; Z/N reflect the stored value.
- NOP: no write, flags held, result_valid pulses.
- RADD (acc[sel] += data_in, cnt_in times):
  - Accepting edge latches sel, data_in and cnt_in.
  - cnt_in=0: go to DONE, acc unchanged.
  - cnt_in>0: go to RUN, op_ready=0.
  - RUN: one add per cycle; counter decrements; after the last add go to DONE.
  - DONE: result_valid=1 for one cycle, op_ready=0, then IDLE.
  - Latency accept to result_valid = cnt_in+1 cycles.
  - C and V are sticky-ORed over the run; SAT clamps each step.
  - cnt_in=0 flags: Z/N from the current acc, C=V=0.
  - acc_out reflects intermediate values during RUN.
- Bad command (sel>=NUM_ACC, or op 6/7):
  - Accepted; no acc write; flags held.
  - Single-cycle timing: result_valid=1 with err=1.
- err=0 for all other completions. Flags hold between completions.

Decomposition:
- Package acc_pkg: op encodings (NOP..RADD), FSM state encoding, flag-bundle struct {z,c,v,n}.
- Sub-module acc_alu: combinational; inputs a, b, sub, sat; outputs result and flags. Parametrised by WIDTH; used by all arithmetic ops.

Test Plan (WIDTH=8, NUM_ACC=4, CNT_W=4, SAT=0 unless stated):
- Reset then LOAD sel=1, data=0xA5 -> next cycle acc_out(rd_sel=1)=0xA5, result_valid=1, N=1, Z=0; other accs read 0.
- LOAD 0x7F to acc0, ADD 0x01 -> acc0=0x80, V=1, C=0, N=1. ADD 0x80 -> acc0=0x00, C=1, V=1, Z=1.
- SUB with acc2=0x10, data=0x20 -> 0xF0, C=1. Repeat with SAT=1 -> 0x00, C=1, Z=1.
- RADD sel=3, acc3=0, data=0x05, cnt=3:
  - op_ready low 4 cycles; result_valid on cycle 4; acc3=0x0F.
  - op_valid held during RUN is not accepted.
  - cnt=0 variant: result_valid after 1 cycle, acc unchanged.
- Start RADD data=0x10, cnt=15; assert rst=0 after 2 adds -> all accs 0 immediately, op_ready=1 after release, no result_valid pulse.
- With NUM_ACC=3: command with sel=3, and separately op=6 -> result_valid=1, err=1, no accumulator changes.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared types for the accumulator bank: opcodes, FSM states and the status-flag bundle.
package acc_pkg;

  typedef enum logic [2:0] {
    OpNop  = 3'd0,
    OpLoad = 3'd1,
    OpAdd  = 3'd2,
    OpSub  = 3'd3,
    OpClr  = 3'd4,
    OpRadd = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  typedef struct packed {
    logic z;
    logic c;
    logic v;
    logic n;
  } flags_t;

endpackage

// File: rtl/acc_bank_if.sv
// Command/response bundle between the control unit (master) and the accumulator bank (slave).
interface acc_bank_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SEL_W = 2,
  parameter int unsigned CNT_W = 4
) ();
  logic             op_valid;
  logic             op_ready;
  logic [2:0]       op;
  logic [SEL_W-1:0] sel;
  logic [WIDTH-1:0] data_in;
  logic [CNT_W-1:0] cnt_in;
  logic [SEL_W-1:0] rd_sel;
  logic [WIDTH-1:0] acc_out;
  logic             result_valid;
  logic             err;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;
  logic             flag_n;

  modport master (
    output op_valid, op, sel, data_in, cnt_in, rd_sel,
    input  op_ready, acc_out, result_valid, err, flag_z, flag_c, flag_v, flag_n
  );

  modport slave (
    input  op_valid, op, sel, data_in, cnt_in, rd_sel,
    output op_ready, acc_out, result_valid, err, flag_z, flag_c, flag_v, flag_n
  );
endinterface

// File: rtl/acc_alu.sv
// Combinational add/subtract with optional unsigned saturation; flags describe the raw operation
// except Z/N, which follow the (possibly clamped) result.
module acc_alu
  import acc_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  input  logic             sat_i,
  output logic [WIDTH-1:0] res_o,
  output flags_t           flags_o
);
  logic [WIDTH:0] raw;
  logic           ovf;

  always_comb begin
    raw = sub_i ? ({1'b0, a_i} - {1'b0, b_i}) : ({1'b0, a_i} + {1'b0, b_i});
    // For subtraction the extra bit is the borrow (a < b unsigned).
    if (sub_i) begin
      ovf = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (raw[WIDTH-1] != a_i[WIDTH-1]);
    end else begin
      ovf = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (raw[WIDTH-1] != a_i[WIDTH-1]);
    end
    res_o = raw[WIDTH-1:0];
    if (sat_i && raw[WIDTH]) begin
      res_o = sub_i ? '0 : '1;
    end
    flags_o = '{z: (res_o == '0), c: raw[WIDTH], v: ovf, n: res_o[WIDTH-1]};
  end
endmodule

// File: rtl/acc_bank.sv
// Bank of NUM_ACC accumulators with load/add/sub/clear and a multi-cycle repeated add,
// accepting one command at a time over a valid/ready handshake.
module acc_bank
  import acc_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_ACC = 4,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned SAT     = 0,
  parameter int unsigned SEL_W   = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
  input  logic        clk,
  input  logic        rst,
  acc_bank_if.slave   bus
);
  localparam logic [SEL_W:0] NumAccL = (SEL_W + 1)'(NUM_ACC);
  localparam bit SatEn = (SAT != 0);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q [NUM_ACC];
  logic [WIDTH-1:0] acc_d [NUM_ACC];
  flags_t           flags_q, flags_d, alu_flags;
  logic             rv_q, rv_d, err_q, err_d;
  logic             stick_c_q, stick_c_d, stick_v_q, stick_v_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] rsel_q, rsel_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [WIDTH-1:0] a_val, b_val, alu_res;
  logic             run, sel_ok, alu_sub;

  assign run     = (state_q == StRun);
  assign sel_ok  = ({1'b0, bus.sel} < NumAccL);
  assign b_val   = run ? rdata_q : bus.data_in;
  assign alu_sub = !run && (bus.op == OpSub);

  // One ALU serves both the single-cycle ops and every step of a repeated add.
  always_comb begin
    a_val = '0;
    if (run) begin
      a_val = acc_q[rsel_q];
    end else if (sel_ok) begin
      a_val = acc_q[bus.sel];
    end
  end

  acc_alu #(.WIDTH(WIDTH)) u_alu (
    .a_i     (a_val),
    .b_i     (b_val),
    .sub_i   (alu_sub),
    .sat_i   (SatEn),
    .res_o   (alu_res),
    .flags_o (alu_flags)
  );

  always_comb begin
    bus.acc_out = '0;
    if ({1'b0, bus.rd_sel} < NumAccL) begin
      bus.acc_out = acc_q[bus.rd_sel];
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    flags_d   = flags_q;
    rv_d      = 1'b0;
    err_d     = 1'b0;
    cnt_d     = cnt_q;
    rsel_d    = rsel_q;
    rdata_d   = rdata_q;
    stick_c_d = stick_c_q;
    stick_v_d = stick_v_q;
    unique case (state_q)
      StIdle: begin
        if (bus.op_valid) begin
          rv_d = 1'b1;
          if (!sel_ok || (bus.op > OpRadd)) begin
            err_d = 1'b1;
          end else begin
            case (bus.op)
              OpLoad: begin
                acc_d[bus.sel] = bus.data_in;
                flags_d = '{z: (bus.data_in == '0), c: 1'b0, v: 1'b0, n: bus.data_in[WIDTH-1]};
              end
              OpAdd, OpSub: begin
                acc_d[bus.sel] = alu_res;
                flags_d        = alu_flags;
              end
              OpClr: begin
                acc_d[bus.sel] = '0;
                flags_d        = '{z: 1'b1, c: 1'b0, v: 1'b0, n: 1'b0};
              end
              OpRadd: begin
                rsel_d    = bus.sel;
                rdata_d   = bus.data_in;
                cnt_d     = bus.cnt_in;
                stick_c_d = 1'b0;
                stick_v_d = 1'b0;
                // The completion pulse is raised on entry to StDone instead.
                if (bus.cnt_in == '0) begin
                  state_d = StDone;
                  flags_d = '{z: (a_val == '0), c: 1'b0, v: 1'b0, n: a_val[WIDTH-1]};
                end else begin
                  state_d = StRun;
                  rv_d    = 1'b0;
                end
              end
              default: ;
            endcase
          end
        end
      end
      StRun: begin
        acc_d[rsel_q] = alu_res;
        stick_c_d     = stick_c_q | alu_flags.c;
        stick_v_d     = stick_v_q | alu_flags.v;
        cnt_d         = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = StDone;
          rv_d    = 1'b1;
          flags_d = '{z: alu_flags.z, c: stick_c_d, v: stick_v_d, n: alu_flags.n};
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      for (int i = 0; i < int'(NUM_ACC); i++) acc_q[i] <= '0;
      flags_q   <= '0;
      rv_q      <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      rsel_q    <= '0;
      rdata_q   <= '0;
      stick_c_q <= 1'b0;
      stick_v_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      flags_q   <= flags_d;
      rv_q      <= rv_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      rsel_q    <= rsel_d;
      rdata_q   <= rdata_d;
      stick_c_q <= stick_c_d;
      stick_v_q <= stick_v_d;
    end
  end

  assign bus.op_ready     = (state_q == StIdle);
  assign bus.result_valid = rv_q;
  assign bus.err          = err_q;
  assign bus.flag_z       = flags_q.z;
  assign bus.flag_c       = flags_q.c;
  assign bus.flag_v       = flags_q.v;
  assign bus.flag_n       = flags_q.n;
endmodule

// File: tb/tb_acc_bank.sv
// Drives three banks in lockstep (default, saturating, NUM_ACC=3) and checks each against a
// transaction-level model every cycle.
module tb_acc_bank;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       op_valid = 1'b0;
  logic [2:0] op = '0;
  logic [1:0] sel = '0;
  logic [1:0] rd_sel;
  logic [7:0] data_in = '0;
  logic [3:0] cnt_in = '0;

  logic [2:0] rv_w, rdy_w, err_w;
  logic [3:0] fl_w [3];
  logic [7:0] ao_w [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    acc_bank_if #(.WIDTH(8), .SEL_W(2), .CNT_W(4)) bus ();
    assign bus.op_valid = op_valid;
    assign bus.op       = op;
    assign bus.sel      = sel;
    assign bus.data_in  = data_in;
    assign bus.cnt_in   = cnt_in;
    assign bus.rd_sel   = rd_sel;
    assign rv_w[g]      = bus.result_valid;
    assign rdy_w[g]     = bus.op_ready;
    assign err_w[g]     = bus.err;
    assign fl_w[g]      = {bus.flag_z, bus.flag_c, bus.flag_v, bus.flag_n};
    assign ao_w[g]      = bus.acc_out;
    acc_bank #(
      .WIDTH  (8),
      .NUM_ACC((g == 2) ? 3 : 4),
      .CNT_W  (4),
      .SAT    ((g == 1) ? 1 : 0)
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  int nacc [3] = '{4, 4, 3};
  int satv [3] = '{0, 1, 0};
  int m_acc [3][4];
  int m_fl [3];
  int m_err [3];
  int done_at [3];
  int bfrom [3];
  int buntil [3];
  int cyc = 0;
  int total = 0;
  int bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int k, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h exp=%0h", nm, k, cyc, got, exp);
    end
  endtask

  function automatic int fl(input int z, input int c, input int v, input int n);
    return z * 8 + c * 4 + v * 2 + n;
  endfunction

  function automatic int sgn(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  task automatic alu(input int a, input int b, input bit sub, input int sat,
                     output int r, output int c, output int v);
    int s, ss;
    if (sub) begin
      s = a - b; c = (a < b) ? 1 : 0; ss = sgn(a) - sgn(b);
    end else begin
      s = a + b; c = (s > 255) ? 1 : 0; ss = sgn(a) + sgn(b);
    end
    v = (ss > 127 || ss < -128) ? 1 : 0;
    r = s & 255;
    if (sat != 0 && c != 0) r = sub ? 0 : 255;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) m_acc[k][i] = 0;
      m_fl[k] = 0; m_err[k] = 0; done_at[k] = -100; bfrom[k] = 1; buntil[k] = 0;
    end
  endtask

  // Whole command resolved at acceptance; a is the cycle right after the accepting edge.
  task automatic model_accept(input int k, input int a);
    int s, o, d, n, x, r, c, v, sc, sv;
    s = int'(sel); o = int'(op); d = int'(data_in); n = int'(cnt_in);
    bfrom[k] = 1; buntil[k] = 0; done_at[k] = a; m_err[k] = 0;
    if (s >= nacc[k] || o > 5) begin
      m_err[k] = 1;
    end else begin
      x = m_acc[k][s];
      case (o)
        1: begin m_acc[k][s] = d; m_fl[k] = fl(d == 0, 0, 0, d >= 128); end
        2, 3: begin
          alu(x, d, o == 3, satv[k], r, c, v);
          m_acc[k][s] = r; m_fl[k] = fl(r == 0, c, v, r >= 128);
        end
        4: begin m_acc[k][s] = 0; m_fl[k] = fl(1, 0, 0, 0); end
        5: begin
          sc = 0; sv = 0;
          for (int i = 0; i < n; i++) begin
            alu(x, d, 1'b0, satv[k], r, c, v);
            x = r; sc |= c; sv |= v;
          end
          m_acc[k][s] = x; m_fl[k] = fl(x == 0, sc, sv, x >= 128);
          done_at[k] = a + n; bfrom[k] = a; buntil[k] = a + n;
        end
        default: ;
      endcase
    end
  endtask

  function automatic bit busy(input int k);
    return (cyc >= bfrom[k]) && (cyc <= buntil[k]);
  endfunction

  initial begin
    rd_sel = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        chk("result_valid", k, int'(rv_w[k]), int'(cyc == done_at[k]));
        chk("op_ready", k, int'(rdy_w[k]), int'(!busy(k)));
        if (cyc == done_at[k]) chk("err", k, int'(err_w[k]), m_err[k]);
        if (cyc == done_at[k] || !busy(k)) chk("flags_zcvn", k, int'(fl_w[k]), m_fl[k]);
      end
      for (int i = 0; i < 4; i++) begin
        rd_sel = 2'(i);
        #1;
        for (int k = 0; k < 3; k++) begin
          if (!busy(k)) chk($sformatf("acc_out[%0d]", i), k, int'(ao_w[k]),
                            (i < nacc[k]) ? m_acc[k][i] : 0);
        end
      end
    end
  end

  // Caller sits just after a rising edge with every bank idle.
  task automatic issue(input int o, input int s, input int d, input int n);
    op = 3'(o); sel = 2'(s); data_in = 8'(d); cnt_in = 4'(n); op_valid = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) model_accept(k, cyc);
    op_valid = 1'b0;
  endtask

  // Optionally keeps a bogus command valid while every bank is busy; none may take it.
  task automatic wait_idle(input bit hold);
    int guard = 0;
    while ((busy(0) || busy(1) || busy(2)) && guard < 40) begin
      op_valid = hold && busy(0) && busy(1) && busy(2);
      if (op_valid) begin
        op = 3'($urandom_range(0, 4)); data_in = 8'($urandom);
      end
      @(posedge clk); #1;
      guard++;
    end
    op_valid = 1'b0;
    if (guard >= 40) chk("idle_timeout", 0, guard, 0);
  endtask

  task automatic lit(input string nm, input int got, input int exp);
    chk(nm, 0, got, exp);
  endtask

  initial begin
    int o;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    issue(1, 1, 'hA5, 0);
    lit("load_a5", m_acc[0][1], 'hA5);
    lit("load_a5_flags", m_fl[0], fl(0, 0, 0, 1));
    issue(1, 0, 'h7F, 0);
    issue(2, 0, 'h01, 0);
    lit("add_7f_1", m_acc[0][0], 'h80);
    lit("add_7f_1_flags", m_fl[0], fl(0, 0, 1, 1));
    issue(2, 0, 'h80, 0);
    lit("add_80_80", m_acc[0][0], 'h00);
    lit("add_80_80_flags", m_fl[0], fl(1, 1, 1, 0));
    issue(1, 2, 'h10, 0);
    issue(3, 2, 'h20, 0);
    lit("sub_wrap", m_acc[0][2], 'hF0);
    lit("sub_wrap_flags", m_fl[0], fl(0, 1, 0, 1));
    lit("sub_sat", m_acc[1][2], 'h00);
    lit("sub_sat_flags", m_fl[1], fl(1, 1, 0, 0));

    issue(4, 3, 0, 0);
    issue(5, 3, 'h05, 3);
    lit("radd_latency", done_at[0] - cyc, 3);
    wait_idle(1'b1);
    lit("radd_result", m_acc[0][3], 'h0F);
    lit("bad_sel_err", m_err[2], 1);
    issue(5, 2, 'h07, 2);
    wait_idle(1'b1);
    issue(5, 0, 'h09, 0);
    lit("radd_cnt0_latency", done_at[0] - cyc, 0);
    lit("radd_cnt0_acc", m_acc[0][0], 'h00);
    wait_idle(1'b0);
    issue(6, 0, 'h01, 0);
    lit("op6_err", m_err[0], 1);
    issue(7, 1, 'h01, 0);

    issue(5, 0, 'h10, 15);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    model_reset();
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;

    for (int t = 0; t < 300; t++) begin
      o = $urandom_range(0, 7);
      if ($urandom_range(0, 3) == 0) o = 5;
      issue(o, $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 6));
      wait_idle(1'($urandom_range(0, 1)));
    end

    repeat (2) begin @(posedge clk); #1; end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
